// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding, datapath widths and the fetch-buffer entry layout.
package rv_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] PC_STEP    = 32'd4;
    localparam logic [1:0]      FIFO_DEPTH = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer of {instr, pc} with push, pop and flush.
// The head entry is always in head_q so the outputs need no read mux.
module fetch_fifo
    import rv_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  logic [ILEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [1:0]      count_o,
    output logic [ILEN-1:0] head_instr_o,
    output logic [XLEN-1:0] head_pc_o
);

    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    fetch_entry_t din;
    logic         push_ok;
    logic         pop_ok;

    assign din     = '{instr: instr_i, pc: pc_i};
    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign push_ok = push_i && ((count_q != FIFO_DEPTH) || pop_ok);

    // Shift-style buffer: a pop moves the tail into the head slot.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) head_d = din;
                    else                 tail_d = din;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == FIFO_DEPTH) begin
                        head_d = tail_q;
                        tail_d = din;
                    end else begin
                        head_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_instr_o = head_q.instr;
    assign head_pc_o    = head_q.pc;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the PC to a combinational instruction memory and
// buffers fetched words for decode; execute-stage redirects flush and retarget the PC.
module instruction_fetch
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        misalign_fault
);

    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("instruction_fetch: RESET_PC must be word aligned");
    end

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;

    logic [1:0]      count;
    logic            redirect_take;
    logic            redirect_bad;
    logic            fetch_en;
    logic            pop;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (redirect_valid && is_misaligned(redirect_pc)) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Output / control logic; redirects outrank both push and pop.
    always_comb begin
        redirect_take = (state_q == RUN) && redirect_valid;
        redirect_bad  = redirect_take && is_misaligned(redirect_pc);
        fetch_en      = (state_q == RUN) && !redirect_valid && (count < FIFO_DEPTH);
        pop           = out_valid && out_ready && !redirect_take;
    end

    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q | redirect_bad;
        if (redirect_take) pc_d = redirect_pc;
        else if (fetch_en) pc_d = pc_q + PC_STEP;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    fetch_fifo u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (fetch_en),
        .pop_i        (pop),
        .flush_i      (redirect_take),
        .instr_i      (imem_rdata),
        .pc_i         (pc_q),
        .count_o      (count),
        .head_instr_o (out_instr),
        .head_pc_o    (out_pc)
    );

    assign imem_addr      = pc_q;
    assign out_valid      = (count != 2'd0);
    assign misalign_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a scoreboard queue of expected fetch
// addresses is filled per scenario and drained as decode accepts instructions.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] IOFS   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_fault;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] held_pc;

    always #5 clk = ~clk;

    // Instruction memory model: word at address A reads as A + 0x13.
    assign imem_rdata = imem_addr + IOFS;

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_fault (misalign_fault)
    );

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid[%0d] got %b exp 0", i, out_valid); end
            checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr[%0d] got %h exp 0", i, out_instr); end
            checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc[%0d] got %h exp 0", i, out_pc); end
            checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL rst_fault[%0d] got %b exp 0", i, misalign_fault); end
            checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL rst_addr[%0d] got %h exp %h", i, imem_addr, RST_PC); end
            reset = 1'b0;
            if (i == 0) @(negedge clk);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 12; i++) exp_q.push_back(RST_PC + 32'(i * 4));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, out_valid);
            end else begin
                exp_pc = exp_q.pop_front();
                checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, out_pc, exp_pc); end
                checks++; if (out_instr !== exp_pc + IOFS) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i, out_instr, exp_pc + IOFS); end
            end
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        out_ready = 1'b0;
        held_pc = exp_q[0];
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, out_valid); end
            checks++; if (out_pc !== held_pc) begin errors++; $display("FAIL stall_pc[%0d] got %h exp %h", i, out_pc, held_pc); end
            checks++; if (out_instr !== held_pc + IOFS) begin errors++; $display("FAIL stall_instr[%0d] got %h exp %h", i, out_instr, held_pc + IOFS); end
        end
        checks++; if (imem_addr !== held_pc + 32'd8) begin errors++; $display("FAIL stall_addr got %h exp %h", imem_addr, held_pc + 32'd8); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL resume_valid[%0d] got %b exp 1", i, out_valid);
            end else begin
                exp_pc = exp_q.pop_front();
                checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL resume_pc[%0d] got %h exp %h", i, out_pc, exp_pc); end
                checks++; if (out_instr !== exp_pc + IOFS) begin errors++; $display("FAIL resume_instr[%0d] got %h exp %h", i, out_instr, exp_pc + IOFS); end
            end
        end
    endtask

    task automatic test_redirect(input logic [31:0] target, input int nbeats, input string tag);
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = target;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_flush_valid got %b exp 0", tag, out_valid); end
        checks++; if (imem_addr !== target) begin errors++; $display("FAIL %s_addr got %h exp %h", tag, imem_addr, target); end
        redirect_valid = 1'b0; out_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < nbeats; i++) exp_q.push_back(target + 32'(i * 4));
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL %s_valid[%0d] got %b exp 1", tag, i, out_valid);
            end else begin
                exp_pc = exp_q.pop_front();
                checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL %s_pc[%0d] got %h exp %h", tag, i, out_pc, exp_pc); end
                checks++; if (out_instr !== exp_pc + IOFS) begin errors++; $display("FAIL %s_instr[%0d] got %h exp %h", tag, i, out_instr, exp_pc + IOFS); end
            end
        end
    endtask

    task automatic test_misalign();
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0042;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            redirect_valid = (i == 1);
            redirect_pc    = (i == 1) ? 32'h0000_0100 : 32'h0000_0042;
            checks++; if (misalign_fault !== 1'b1) begin errors++; $display("FAIL mis_fault[%0d] got %b exp 1", i, misalign_fault); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mis_valid[%0d] got %b exp 0", i, out_valid); end
            checks++; if (imem_addr !== 32'h0000_0042) begin errors++; $display("FAIL mis_addr[%0d] got %h exp 00000042", i, imem_addr); end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset_redirect();
        reset = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== RST_PC) begin errors++; $display("FAIL rr_fill got valid=%b pc=%h exp valid=1 pc=%h", out_valid, out_pc, RST_PC); end
        checks++; if (imem_addr !== RST_PC + 32'd8) begin errors++; $display("FAIL rr_full_addr got %h exp %h", imem_addr, RST_PC + 32'd8); end
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0082;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_valid got %b exp 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rr_pc got %h exp 0", out_pc); end
        checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL rr_fault got %b exp 0", misalign_fault); end
        checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL rr_addr got %h exp %h", imem_addr, RST_PC); end
        // Redirect still held while the FSM is in IDLE: it must be ignored.
        reset = 1'b0;
        @(negedge clk);
        checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL rr_idle_fault got %b exp 0", misalign_fault); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_idle_valid got %b exp 0", out_valid); end
        checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL rr_idle_addr got %h exp %h", imem_addr, RST_PC); end
        redirect_valid = 1'b0; out_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(RST_PC + 32'(i * 4));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL rr_run_valid[%0d] got %b exp 1", i, out_valid);
            end else begin
                exp_pc = exp_q.pop_front();
                checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL rr_run_pc[%0d] got %h exp %h", i, out_pc, exp_pc); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect(32'h0000_0040, 3, "redir");
        test_redirect(32'hFFFF_FFF8, 4, "wrap");
        test_misalign();
        test_reset_redirect();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
